div_result_bcd: RTL and testbench

Downstream stage of the 8-bit ÷ 4-bit divider. When the controller signals that the divider result is valid, this block captures the quotient (ANS) and the remainder (ARE). It converts both to packed BCD with a sequential shift-and-add-3 (double-dabble) engine and presents the digits, with a one-cycle DONE pulse, to the display/output logic. A divide-by-zero flag bypasses conversion and produces an error pattern.

---
 rtl/div_pkg.sv | 9 +
 rtl/bcd_dabble_lane.sv | 38 +++
 rtl/div_result_bcd.sv | 91 +++++++++
 tb/tb_div_result_bcd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: divider widths, BCD digit counts, error nibble and result-stage FSM encoding.
package div_pkg;
    localparam int QW = 8;
    localparam int RW = 4;
    localparam int QD = 3;
    localparam int RD = 2;
    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;
    typedef enum logic [1:0] {IDLE, SHIFT, ERRS, FIN} state_t;
endpackage

// File: rtl/bcd_dabble_lane.sv
// bcd_dabble_lane: one double-dabble lane, a W-bit binary shifter feeding ND BCD nibbles.
module bcd_dabble_lane #(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [W-1:0]    bin_i,
    output logic [4*ND-1:0] bcd_o
);
    logic [4*ND-1:0] bcd_q, bcd_d, adj;
    logic [W-1:0]    bin_q, bin_d;
    for (genvar i = 0; i < ND; i++) begin : g_adj
        assign adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end
    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        if (load_i) begin
            bcd_d = '0;
            bin_d = bin_i;
        end else if (shift_i) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcd_q <= '0;
            bin_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
        end
    end
    assign bcd_o = bcd_q;
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures divider quotient/remainder, converts both to BCD, flags divide-by-zero.
module div_result_bcd
    import div_pkg::*;
(
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            LOAD,
    input  logic [QW-1:0]   ANS,
    input  logic [RW-1:0]   ARE,
    input  logic            DZERO,
    output logic            BUSY,
    output logic            DONE,
    output logic [4*QD-1:0] QBCD,
    output logic [4*RD-1:0] RBCD,
    output logic            ERR
);
    localparam int CW = $clog2(QW + 1);
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4*QD-1:0] qbcd_q, qbcd_d, q_acc;
    logic [4*RD-1:0] rbcd_q, rbcd_d, r_acc;
    logic            err_q, err_d, done_q, done_d;
    logic            accept, start, shift;
    // DONE cycle is still busy, so a LOAD there is dropped
    assign accept = state_q == IDLE && !done_q && LOAD;
    assign start  = accept && !DZERO;
    assign shift  = state_q == SHIFT;
    bcd_dabble_lane #(.W(QW), .ND(QD)) u_qlane (
        .clk_i(CLOCK), .rst_i(RESET), .load_i(start), .shift_i(shift),
        .bin_i(ANS), .bcd_o(q_acc)
    );
    bcd_dabble_lane #(.W(QW), .ND(RD)) u_rlane (
        .clk_i(CLOCK), .rst_i(RESET), .load_i(start), .shift_i(shift),
        .bin_i({{(QW-RW){1'b0}}, ARE}), .bcd_o(r_acc)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qbcd_d  = qbcd_q;
        rbcd_d  = rbcd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = DZERO ? ERRS : SHIFT;
                cnt_d   = DZERO ? cnt_q : CW'(QW);
            end
            SHIFT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? FIN : SHIFT;
            end
            FIN: begin
                qbcd_d  = q_acc;
                rbcd_d  = r_acc;
                err_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERRS: begin
                qbcd_d  = {QD{BCD_ERR_NIBBLE}};
                rbcd_d  = {RD{BCD_ERR_NIBBLE}};
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qbcd_q  <= '0;
            rbcd_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qbcd_q  <= qbcd_d;
            rbcd_q  <= rbcd_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
    assign BUSY = state_q != IDLE || done_q;
    assign DONE = done_q;
    assign QBCD = qbcd_q;
    assign RBCD = rbcd_q;
    assign ERR  = err_q;
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: scoreboard bench for the divider result BCD stage.
module tb_div_result_bcd;
    logic        CLOCK = 0, RESET = 0, LOAD = 0, DZERO = 0;
    logic [7:0]  ANS = 0;
    logic [3:0]  ARE = 0;
    logic        BUSY, DONE, ERR;
    logic [11:0] QBCD;
    logic [7:0]  RBCD;
    int checks = 0, errors = 0;

    typedef struct {
        logic [11:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
    } exp_t;
    exp_t sb[$];

    div_result_bcd dut (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .ANS(ANS), .ARE(ARE),
        .DZERO(DZERO), .BUSY(BUSY), .DONE(DONE), .QBCD(QBCD), .RBCD(RBCD), .ERR(ERR)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [11:0] to_bcd(int v);
        logic [11:0] b;
        b[11:8] = 4'(v / 100);
        b[7:4]  = 4'((v / 10) % 10);
        b[3:0]  = 4'(v % 10);
        return b;
    endfunction

    task automatic issue(input int a, input int r, input bit dz);
        exp_t e;
        logic [11:0] rb;
        rb    = to_bcd(r);
        e.q   = dz ? 12'hFFF : to_bcd(a);
        e.r   = dz ? 8'hFF : rb[7:0];
        e.e   = dz;
        e.lat = dz ? 1 : 9;
        sb.push_back(e);
        @(negedge CLOCK);
        LOAD = 1; ANS = 8'(a); ARE = 4'(r); DZERO = dz;
        @(negedge CLOCK);
        LOAD = 0; ANS = 8'hxx; ARE = 4'hx; DZERO = 1'bx;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        while (!DONE && cyc < 20) begin
            @(negedge CLOCK);
            cyc++;
        end
        to = !DONE;
    endtask

    task automatic test_reset;
        @(negedge CLOCK);
        RESET = 1; LOAD = 1; ANS = 8'd77; ARE = 4'd5; DZERO = 0;
        repeat (2) @(negedge CLOCK);
        RESET = 0; LOAD = 0;
        checks++;
        if ({BUSY, DONE, ERR, QBCD, RBCD} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b err=%b q=%h r=%h want all 0", BUSY, DONE, ERR, QBCD, RBCD);
        end
        @(negedge CLOCK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start got busy=%b want 0", BUSY);
        end
    endtask

    task automatic test_basic;
        int cyc, busy_cnt;
        bit to;
        exp_t e;
        sb.push_back('{q: to_bcd(14), r: 8'h03, e: 1'b0, lat: 9});
        @(negedge CLOCK);
        LOAD = 1; ANS = 8'd14; ARE = 4'd3; DZERO = 0;
        @(negedge CLOCK);
        LOAD = 0;
        busy_cnt = 0;
        cyc = 0;
        while (!DONE && cyc < 20) begin
            busy_cnt += int'(BUSY);
            @(negedge CLOCK);
            cyc++;
        end
        to = !DONE;
        busy_cnt += int'(BUSY);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat) begin
            errors++;
            $display("FAIL basic_latency got %0d timeout=%b want %0d", cyc, to, e.lat);
        end
        checks++;
        if (QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
            errors++;
            $display("FAIL basic_result got q=%h r=%h err=%b want q=%h r=%h err=%b", QBCD, RBCD, ERR, e.q, e.r, e.e);
        end
        @(negedge CLOCK);
        checks++;
        if (busy_cnt != 10 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy_cycles=%0d busy_after=%b done_after=%b want 10 0 0", busy_cnt, BUSY, DONE);
        end
    endtask

    task automatic test_extremes;
        int cyc;
        bit to;
        exp_t e;
        issue(255, 15, 0);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat || QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
            errors++;
            $display("FAIL max_result got lat=%0d q=%h r=%h err=%b want lat=%0d q=%h r=%h err=%b", cyc, QBCD, RBCD, ERR, e.lat, e.q, e.r, e.e);
        end
        issue(0, 0, 0);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat || QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
            errors++;
            $display("FAIL zero_back_to_back got lat=%0d q=%h r=%h err=%b want lat=%0d q=%h r=%h err=%b", cyc, QBCD, RBCD, ERR, e.lat, e.q, e.r, e.e);
        end
        for (int k = 0; k < 4; k++) begin
            int a, r;
            a = int'($urandom_range(255));
            r = int'($urandom_range(15));
            issue(a, r, 0);
            wait_done(cyc, to);
            e = sb.pop_front();
            checks++;
            if (to || QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
                errors++;
                $display("FAIL random_%0d a=%0d r=%0d got q=%h r=%h err=%b want q=%h r=%h err=%b", k, a, r, QBCD, RBCD, ERR, e.q, e.r, e.e);
            end
        end
    endtask

    task automatic test_dzero;
        int cyc;
        bit to;
        exp_t e;
        issue(37, 2, 1);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat) begin
            errors++;
            $display("FAIL dzero_latency got %0d timeout=%b want %0d", cyc, to, e.lat);
        end
        checks++;
        if (QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
            errors++;
            $display("FAIL dzero_result got q=%h r=%h err=%b want q=%h r=%h err=%b", QBCD, RBCD, ERR, e.q, e.r, e.e);
        end
        issue(100, 9, 0);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat || QBCD !== e.q || RBCD !== e.r || ERR !== e.e) begin
            errors++;
            $display("FAIL after_dzero got lat=%0d q=%h r=%h err=%b want lat=%0d q=%h r=%h err=%b", cyc, QBCD, RBCD, ERR, e.lat, e.q, e.r, e.e);
        end
    endtask

    task automatic test_busy_drop;
        int cyc, extra;
        bit to;
        exp_t e;
        issue(42, 6, 0);
        @(negedge CLOCK);
        LOAD = 1; ANS = 8'd1; ARE = 4'd1; DZERO = 0;
        @(negedge CLOCK);
        LOAD = 0;
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.lat - 2 || QBCD !== e.q || RBCD !== e.r) begin
            errors++;
            $display("FAIL busy_drop got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", cyc + 2, QBCD, RBCD, e.lat, e.q, e.r);
        end
        LOAD = 1; ANS = 8'd7; ARE = 4'd7; DZERO = 0;
        @(negedge CLOCK);
        LOAD = 0;
        extra = 0;
        repeat (14) begin
            extra += int'(DONE);
            @(negedge CLOCK);
        end
        checks++;
        if (extra != 0 || QBCD !== e.q || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_drop got extra_done=%0d q=%h busy=%b want 0 %h 0", extra, QBCD, BUSY, e.q);
        end
    endtask

    task automatic test_reset_abort;
        int extra;
        issue(123, 4, 0);
        repeat (3) @(negedge CLOCK);
        RESET = 1;
        @(negedge CLOCK);
        RESET = 0;
        sb.delete();
        extra = 0;
        repeat (14) begin
            extra += int'(DONE);
            @(negedge CLOCK);
        end
        checks++;
        if (extra != 0 || {BUSY, ERR, QBCD, RBCD} !== 22'd0) begin
            errors++;
            $display("FAIL reset_abort got extra_done=%0d busy=%b err=%b q=%h r=%h want 0 and all 0", extra, BUSY, ERR, QBCD, RBCD);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_dzero;
        test_busy_drop;
        test_reset_abort;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
